// File: rtl/bwt_mtf_encoder.sv
// rtl/bwt_mtf_encoder.sv - move-to-front encoder stage for framed BWT output
//
// Purpose: turns the BWT character stream into MTF indices, one per accepted
// character, with a 1-cycle latency and no stall path. The symbol table
// returns to identity at every STRING_LEN-symbol frame boundary.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-low reset
//   valid_in   in   1  char_in is valid this cycle
//   char_in    in   8  BWT output character
//   mtf_idx    out  8  MTF index of the character accepted one cycle earlier
//   valid_out  out  1  mtf_idx valid (1-cycle pulse per accepted char)
//   last_out   out  1  with valid_out: last index of the frame
//   err        out  1  sticky out-of-range character flag
module bwt_mtf_encoder #(
    parameter int STRING_LEN = 64,
    parameter int ALPHABET   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] char_in,
    output logic [7:0] mtf_idx,
    output logic       valid_out,
    output logic       last_out,
    output logic       err
);

    localparam int CNT_W = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STRING_LEN - 1);

    logic [7:0]       tbl_q [ALPHABET];
    logic [7:0]       tbl_d [ALPHABET];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [7:0]       k_idx;
    logic             in_range;
    logic             is_last;

    // The table is always a permutation of 0..ALPHABET-1, so at most one
    // entry matches an in-range character.
    always_comb begin
        k_idx = '0;
        for (int i = 0; i < ALPHABET; i++) begin
            if (tbl_q[i] == char_in) begin
                k_idx = i[7:0];
            end
        end
    end

    assign in_range = (32'(char_in) < ALPHABET);
    assign is_last  = (cnt_q == LAST_CNT);

    always_comb begin
        tbl_d   = tbl_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_d   = err_q;

        if (valid_in) begin
            valid_d = 1'b1;
            last_d  = is_last;
            cnt_d   = is_last ? '0 : cnt_q + 1'b1;

            if (in_range) begin
                idx_d = k_idx;
            end else begin
                idx_d = 8'hFF;
                err_d = 1'b1;
            end

            // The final symbol's index above uses the pre-reload table; the
            // reload takes priority over the MTF shift so the next frame
            // starts from identity regardless of what was just encoded.
            if (is_last) begin
                for (int i = 0; i < ALPHABET; i++) begin
                    tbl_d[i] = i[7:0];
                end
            end else if (in_range) begin
                tbl_d[0] = char_in;
                for (int j = 1; j < ALPHABET; j++) begin
                    if (j[7:0] <= k_idx) begin
                        tbl_d[j] = tbl_q[j-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ALPHABET; i++) begin
                tbl_q[i] <= i[7:0];
            end
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tbl_q   <= tbl_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign mtf_idx   = idx_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bwt_mtf_encoder.sv
// tb/tb_bwt_mtf_encoder.sv - self-checking bench for bwt_mtf_encoder
module tb_bwt_mtf_encoder;

    localparam int ND = 3;
    // Instance 0: 256/64, instance 1: 256/4, instance 2: 16/4
    localparam int ALPH [ND] = '{256, 256, 16};
    localparam int SLEN [ND] = '{64, 4, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] char_in = 8'd0;

    logic [7:0] idx_w   [ND];
    logic       vld_w   [ND];
    logic       last_w  [ND];
    logic       err_w   [ND];

    int compared = 0;
    int mismatched = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    bwt_mtf_encoder #(.STRING_LEN(64), .ALPHABET(256)) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .char_in(char_in),
        .mtf_idx(idx_w[0]), .valid_out(vld_w[0]), .last_out(last_w[0]), .err(err_w[0]));

    bwt_mtf_encoder #(.STRING_LEN(4), .ALPHABET(256)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .char_in(char_in),
        .mtf_idx(idx_w[1]), .valid_out(vld_w[1]), .last_out(last_w[1]), .err(err_w[1]));

    bwt_mtf_encoder #(.STRING_LEN(4), .ALPHABET(16)) dut_c (
        .clk(clk), .rst(rst), .valid_in(valid_in), .char_in(char_in),
        .mtf_idx(idx_w[2]), .valid_out(vld_w[2]), .last_out(last_w[2]), .err(err_w[2]));

    task automatic chk(input string nm, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Software MTF model: a list of symbols, most recently used first.
    int         tq [ND][$];
    int         mcnt [ND];
    int         e_idx [ND];
    bit         e_v [ND];
    bit         e_l [ND];
    bit         e_e [ND];

    function automatic void model_table_init(input int d);
        tq[d].delete();
        for (int i = 0; i < ALPH[d]; i++) tq[d].push_back(i);
    endfunction

    function automatic void model_step(input int d, input int ch);
        int k;
        bit frame_end;
        frame_end = (mcnt[d] == SLEN[d] - 1);
        e_v[d] = 1'b1;
        e_l[d] = frame_end;
        if (ch >= ALPH[d]) begin
            e_idx[d] = 255;
            e_e[d] = 1'b1;
        end else begin
            k = -1;
            foreach (tq[d][i]) if (tq[d][i] == ch && k < 0) k = i;
            e_idx[d] = k;
            tq[d].delete(k);
            tq[d].push_front(ch);
        end
        if (frame_end) begin
            mcnt[d] = 0;
            model_table_init(d);
        end else begin
            mcnt[d] = mcnt[d] + 1;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst) begin
                model_table_init(d);
                mcnt[d] = 0;
                e_idx[d] = 0;
                e_v[d] = 1'b0;
                e_l[d] = 1'b0;
                e_e[d] = 1'b0;
            end else if (valid_in) begin
                model_step(d, int'(char_in));
            end else begin
                e_v[d] = 1'b0;
                e_l[d] = 1'b0;
            end
        end
    end

    // Single compare process: every falling edge, all instances vs model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("model_idx[%0d]", d),   int'(idx_w[d]),  e_idx[d]);
                chk($sformatf("model_valid[%0d]", d), int'(vld_w[d]),  int'(e_v[d]));
                chk($sformatf("model_last[%0d]", d),  int'(last_w[d]), int'(e_l[d]));
                chk($sformatf("model_err[%0d]", d),   int'(err_w[d]),  int'(e_e[d]));
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; results are read there too.
    task automatic send(input logic [7:0] ch);
        valid_in = 1'b1;
        char_in  = ch;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [7:0] basic_ch  [5] = '{8'h62, 8'h62, 8'h61, 8'h61, 8'h62};
    logic [7:0] basic_idx [5] = '{8'h62, 8'h00, 8'h62, 8'h00, 8'h01};
    int         frame_idx [5] = '{5, 0, 0, 0, 5};
    int         r7_idx    [4] = '{7, 0, 0, 0};

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("reset_idx",   int'(idx_w[d]),  0);
            chk("reset_valid", int'(vld_w[d]),  0);
            chk("reset_last",  int'(last_w[d]), 0);
            chk("reset_err",   int'(err_w[d]),  0);
        end
        do_reset();
        cmp_en = 1'b1;

        // Basic MTF on 256/64
        for (int i = 0; i < 5; i++) begin
            send(basic_ch[i]);
            chk("basic_idx",   int'(idx_w[0]),  int'(basic_idx[i]));
            chk("basic_valid", int'(vld_w[0]),  1);
            chk("basic_last",  int'(last_w[0]), 0);
        end
        idle();

        // Frame boundary on 256/4
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'h05);
            chk("frame_idx",  int'(idx_w[1]),  frame_idx[i]);
            chk("frame_last", int'(last_w[1]), (i == 3) ? 1 : 0);
        end
        idle();

        // Gapped input on 256/64
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(basic_ch[i]);
            chk("gap_idx",   int'(idx_w[0]), int'(basic_idx[i]));
            chk("gap_valid", int'(vld_w[0]), 1);
            idle();
            chk("gap_valid_low", int'(vld_w[0]), 0);
            chk("gap_idx_hold",  int'(idx_w[0]), int'(basic_idx[i]));
        end

        // Illegal char on 16/4
        do_reset();
        send(8'h20);
        chk("illegal_idx", int'(idx_w[2]), 8'hFF);
        chk("illegal_err", int'(err_w[2]), 1);
        send(8'h03);
        chk("legal_idx",   int'(idx_w[2]), 3);
        chk("sticky_err",  int'(err_w[2]), 1);
        idle();
        repeat (3) idle();
        chk("sticky_err_idle", int'(err_w[2]), 1);

        // Async reset mid-frame on 256/4
        do_reset();
        send(8'h09);
        send(8'h0A);
        valid_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_idx",   int'(idx_w[1]), 0);
        chk("async_valid", int'(vld_w[1]), 0);
        chk("async_err_c", int'(err_w[2]), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'h07);
            chk("post_rst_idx",  int'(idx_w[1]),  r7_idx[i]);
            chk("post_rst_last", int'(last_w[1]), (i == 3) ? 1 : 0);
        end
        idle();

        // Random full frames against the software model
        do_reset();
        for (int f = 0; f < 20; f++) begin
            for (int s = 0; s < 64; s++) begin
                send(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 7) == 0) idle();
            end
        end
        idle();
        idle();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
